// File: rtl/wb_arb.sv
// Writeback arbiter: busy scoreboard, ALU/LSU result arbitration, register-file write port.
// Optional forwarding of the registered write enabled by macro WB_ARB_BYPASS_EN.
module wb_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  output logic        reg_w_EN,
  output logic [4:0]  rw,
  output logic [31:0] rw_data,
  output logic        byp_hit1,
  output logic        byp_hit2,
  output logic [31:0] byp_data1,
  output logic [31:0] byp_data2,
  output logic [31:0] wb_count
);

  logic [31:1] r_busy;
  logic [2:0]  r_starve;
  logic        r_wen;
  logic [4:0]  r_rw;
  logic [31:0] r_data;
  logic [31:0] r_cnt;

  logic [31:0] w_busy;
  logic [31:1] w_busy_nxt;
  logic        w_force;
  logic        w_alu_win;
  logic        w_lsu_win;
  logic        w_fire;
  logic [4:0]  w_rd;
  logic [31:0] w_dat;
  logic        w_iss;

  assign w_busy = {r_busy, 1'b0};

  // ALU overrides LSU priority once it has waited four cycles
  assign w_force   = alu_valid && (r_starve == 3'd4);
  assign w_alu_win = !rst && alu_valid && (!lsu_valid || w_force);
  assign w_lsu_win = !rst && lsu_valid && !w_alu_win;
  assign w_fire    = w_alu_win || w_lsu_win;

  assign alu_ready = w_alu_win;
  assign lsu_ready = !rst && !w_force;

  assign w_rd  = w_alu_win ? alu_rd : lsu_rd;
  assign w_dat = w_alu_win ? alu_data : lsu_data;

  assign iss_ready = !rst && !w_busy[iss_rd];
  assign w_iss     = iss_valid && iss_ready;

  assign rs1_busy = w_busy[rs1];
  assign rs2_busy = w_busy[rs2];

  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 1; i < 32; i++) begin
      if (w_fire && (w_rd == 5'(i)))
        w_busy_nxt[i] = 1'b0;
      if (w_iss && (iss_rd == 5'(i)))
        w_busy_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= '0;
      r_starve <= '0;
      r_wen    <= 1'b0;
      r_rw     <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (alu_valid && !w_alu_win)
        r_starve <= r_starve + 3'd1;
      else
        r_starve <= '0;
      r_wen <= w_fire && (w_rd != 5'd0);
      if (w_fire) begin
        r_rw   <= w_rd;
        r_data <= w_dat;
      end
      if (w_fire && (w_rd != 5'd0))
        r_cnt <= r_cnt + 32'd1;
    end
  end

  assign reg_w_EN = r_wen;
  assign rw       = r_rw;
  assign rw_data  = r_data;
  assign wb_count = r_cnt;

`ifdef WB_ARB_BYPASS_EN
  assign byp_hit1  = r_wen && (r_rw == rs1) && (rs1 != 5'd0);
  assign byp_hit2  = r_wen && (r_rw == rs2) && (rs2 != 5'd0);
  assign byp_data1 = r_data;
  assign byp_data2 = r_data;
`else
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data1 = '0;
  assign byp_data2 = '0;
`endif

endmodule

// File: doc/wb_arb.md
WB_ARB -- requirements
Module: wb_arb

Interface
REQ-001 SHALL have ports: clk input 1 (sole clock, all state updates on posedge); rst input 1 (synchronous, active-high).
REQ-002 SHALL have: iss_valid input 1 (issue stage claims a destination); iss_rd input 5 (destination register); iss_ready output 1 (claim accepted).
REQ-003 SHALL have: rs1, rs2 inputs 5 (decode operand indices); rs1_busy, rs2_busy outputs 1 (pending write on that register).
REQ-004 SHALL have: alu_valid input 1, alu_rd input 5, alu_data input 32, alu_ready output 1 (ALU result channel).
REQ-005 SHALL have: lsu_valid input 1, lsu_rd input 5, lsu_data input 32, lsu_ready output 1 (load result channel).
REQ-006 SHALL have: reg_w_EN output 1, rw output 5, rw_data output 32 (register-file write port).
REQ-007 SHALL have: byp_hit1, byp_hit2 outputs 1 and byp_data1, byp_data2 outputs 32 (forwarding of the registered write).
REQ-008 SHALL have: wb_count output 32 (retired non-x0 writes).

Function
REQ-009 SHALL keep a 32-entry busy scoreboard; busy[0] SHALL read 0 permanently.
REQ-010 SHALL drive iss_ready = !busy[iss_rd] combinationally; issue fires on iss_valid && iss_ready and sets busy[iss_rd] at the next edge (no effect for x0).
REQ-011 SHALL drive rs1_busy = busy[rs1] and rs2_busy = busy[rs2] combinationally.
REQ-012 SHALL accept at most one result per cycle; a channel fires on valid && ready.
REQ-013 SHALL arbitrate with LSU priority by default: lsu_ready = 1 when LSU wins, alu_ready = 1 only when ALU wins; the loser's ready = 0.
REQ-014 SHALL keep a 3-bit starvation counter: increment each cycle alu_valid is held and the ALU loses, clear when the ALU fires or alu_valid = 0.
REQ-015 SHALL grant the ALU over the LSU for the cycle in which the counter equals 4; no channel waits more than 5 cycles.
REQ-016 SHALL register the winner: next edge reg_w_EN = 1, rw = rd, rw_data = data; with no winner reg_w_EN = 0 and rw/rw_data hold.
REQ-017 SHALL accept results with rd = 0, leave reg_w_EN = 0, and not change wb_count.
REQ-018 SHALL clear busy[rd] on the edge on which the result is registered.
REQ-019 SHALL resolve a same-cycle issue and retire on one rd as follows: iss_ready is 0 that cycle (busy still set), and the issue succeeds the next cycle.
REQ-020 SHALL, when a same-cycle issue and retire target different registers, perform both.
REQ-021 SHALL increment wb_count by 1 per registered non-x0 write and wrap from 0xFFFFFFFF to 0.
REQ-022 SHALL have single-cycle latency from result accept to reg_w_EN, with no internal buffering beyond the output register.

Reset
REQ-023 SHALL, while rst is high at posedge, set: busy = 0; reg_w_EN = 0; rw = 0; rw_data = 0; wb_count = 0; starvation counter = 0.
REQ-024 SHALL drive alu_ready = lsu_ready = 0 and iss_ready = 0 during reset.
REQ-025 SHALL discard any result or issue presented in a cycle in which rst is high.

Configuration
REQ-026 SHALL, with macro WB_ARB_BYPASS_EN defined, drive byp_hitN = reg_w_EN && (rw == rsN) && (rsN != 0) and byp_dataN = rw_data.
REQ-027 SHALL, without WB_ARB_BYPASS_EN, tie byp_hit1/2 to 0 and byp_data1/2 to 0 with no bypass logic.

Verification
REQ-028 Issue rd=5 -> next cycle rs1=5 gives rs1_busy=1; ALU result rd=5, data 0x1234 -> next cycle reg_w_EN=1, rw=5, rw_data=0x1234, rs1_busy=0, wb_count=1.
REQ-029 ALU (rd=3, 0xA) and LSU (rd=4, 0xB) valid together -> LSU written first (rw=4), ALU next cycle (rw=3).
REQ-030 LSU valid continuously with ALU valid -> ALU fires on its 5th waiting cycle.
REQ-031 ALU result rd=0, data 0xFFFF -> reg_w_EN=0, wb_count unchanged, alu_ready=1.
REQ-032 Re-issue rd=7 while busy -> iss_ready=0; retire rd=7 -> iss_ready=1 the following cycle.
REQ-033 rst asserted mid-stream with busy[9]=1 and wb_count=12 -> next cycle busy all 0, wb_count=0, reg_w_EN=0; with WB_ARB_BYPASS_EN and rw=2 written, rs2=2 -> byp_hit2=1 and byp_data2=rw_data.
